// File: rtl/circle_raster_pkg.sv
// Shared constants and types for the circle rasteriser: opcodes, engine states,
// and command-word field offsets.
package circle_raster_pkg;

  localparam logic [3:0]  OP_CLEAR      = 4'd0;
  localparam logic [3:0]  OP_DRAW       = 4'd1;
  localparam int unsigned OPC_LSB       = 28;
  localparam int unsigned CMD_FIELD_MAX = 28;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLOT = 2'd1,
    STEP = 2'd2
  } engine_state_t;

  // DRAW payload layout: {r, cy, cx} packed from bit 0 upward
  function automatic int unsigned cy_lsb(input int unsigned xw);
    return xw;
  endfunction

  function automatic int unsigned r_lsb(input int unsigned xw, input int unsigned yw);
    return xw + yw;
  endfunction

endpackage

// File: rtl/circle_engine.sv
// Midpoint circle engine: walks one octant and emits the eight symmetric points,
// skipping any point that falls outside the bitmap.
module circle_engine
  import circle_raster_pkg::*;
#(
  parameter int unsigned XW = 9,
  parameter int unsigned YW = 9,
  parameter int unsigned RW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [XW-1:0] cx,
  input  logic [YW-1:0] cy,
  input  logic [RW-1:0] r,
  output logic          req,
  input  logic          gnt,
  output logic [XW-1:0] px,
  output logic [YW-1:0] py,
  output logic          busy
);

  localparam int unsigned DW  = RW + 2;
  localparam int unsigned XDW = RW + 1;
  // Wide enough that cx+r never wraps and cx-r keeps a sign bit
  localparam int unsigned CW  = ((XW > YW) ? XW : YW) + RW + 2;

  engine_state_t state, state_nx;
  logic [XW-1:0] cx_q, cx_nx;
  logic [YW-1:0] cy_q, cy_nx;
  logic [RW-1:0] x, x_nx, y, y_nx, y_inc, du, dv;
  logic [XDW-1:0] x_dec;
  logic [DW-1:0] d, d_nx;
  logic [2:0] k, k_nx;
  logic [CW-1:0] sx, sy;
  logic clipped, cont;

  // k[2] swaps x/y, k[1] negates the x offset, k[0] negates the y offset
  always_comb begin
    du = k[2] ? y : x;
    dv = k[2] ? x : y;
    sx = k[1] ? CW'(cx_q) - CW'(du) : CW'(cx_q) + CW'(du);
    sy = k[0] ? CW'(cy_q) - CW'(dv) : CW'(cy_q) + CW'(dv);
  end

  assign clipped = (sx[CW-1:XW] != '0) || (sy[CW-1:YW] != '0);
  assign px      = sx[XW-1:0];
  assign py      = sy[YW-1:0];
  assign req     = (state == PLOT) && !clipped;
  assign busy    = (state != IDLE);

  always_comb begin
    state_nx = state;
    cx_nx    = cx_q;
    cy_nx    = cy_q;
    x_nx     = x;
    y_nx     = y;
    d_nx     = d;
    k_nx     = k;
    cont     = 1'b0;
    y_inc    = y + RW'(1);
    x_dec    = {1'b0, x} - XDW'(1);
    unique case (state)
      IDLE: begin
        if (start) begin
          cx_nx    = cx;
          cy_nx    = cy;
          x_nx     = r;
          y_nx     = '0;
          d_nx     = DW'(1) - DW'(r);
          k_nx     = '0;
          state_nx = PLOT;
        end
      end
      PLOT: begin
        if (clipped || gnt) begin
          k_nx = k + 3'd1;
          if (k == 3'd7) state_nx = STEP;
        end
      end
      STEP: begin
        y_nx = y_inc;
        k_nx = '0;
        if (d[DW-1]) begin
          d_nx = d + DW'({y_inc, 1'b1});
          cont = (x >= y_inc);
        end else begin
          // x underflow (r=0 case) ends the circle
          x_nx = x_dec[RW-1:0];
          d_nx = d + DW'({y_inc, 1'b1}) - DW'({x_dec[RW-1:0], 1'b0});
          cont = !x_dec[RW] && (x_dec[RW-1:0] >= y_inc);
        end
        state_nx = cont ? PLOT : IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cx_q  <= '0;
      cy_q  <= '0;
      x     <= '0;
      y     <= '0;
      d     <= '0;
      k     <= '0;
    end else begin
      state <= state_nx;
      cx_q  <= cx_nx;
      cy_q  <= cy_nx;
      x     <= x_nx;
      y     <= y_nx;
      d     <= d_nx;
      k     <= k_nx;
    end
  end

endmodule

// File: rtl/circle_raster_array_ram.sv
// Dual-port single-clock bitmap RAM: port A writes, port B reads (old data on collision).
module circle_raster_array_ram #(
  parameter int unsigned AW         = 18,
  parameter int unsigned DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  we_a,
  input  logic [AW-1:0]         addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  input  logic [AW-1:0]         addr_b,
  output logic [DATA_WIDTH-1:0] rdata_b
);

  logic [DATA_WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= wdata_a;
    rdata_b <= mem[addr_b];
  end

endmodule

// File: rtl/circle_raster_array.sv
// Avalon-MM circle rasteriser: parallel midpoint engines share one round-robin
// arbitrated write port into a 1-bpp bitmap; second RAM port serves readback.
module circle_raster_array
  import circle_raster_pkg::*;
#(
  parameter int unsigned XW      = 9,
  parameter int unsigned YW      = 9,
  parameter int unsigned RW      = 8,
  parameter int unsigned ENGINES = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [XW+YW:0] address,
  input  logic           read,
  output logic [31:0]    readdata,
  output logic           readdatavalid,
  input  logic           write,
  input  logic [31:0]    writedata,
  output logic           waitrequest
);

  localparam int unsigned AW     = XW + YW;
  localparam int unsigned CY_LSB = cy_lsb(XW);
  localparam int unsigned R_LSB  = r_lsb(XW, YW);
  localparam int unsigned EW     = (ENGINES > 1) ? $clog2(ENGINES) : 1;

  if ((XW + YW + RW > CMD_FIELD_MAX) || (ENGINES < 1) || (ENGINES > 8)) begin : g_bad_params
    $error("circle_raster_array: XW+YW+RW must be <= 28 and ENGINES in 1..8");
  end

  logic [3:0] opcode;
  logic is_draw, is_clear, accept, abort_all, found, gnt_any, clearing;
  logic [ENGINES-1:0] busy, req, gnt, start;
  logic [XW-1:0] px [ENGINES];
  logic [YW-1:0] py [ENGINES];
  logic [EW-1:0] ptr, gnt_idx, idx;
  logic [AW-1:0] clr_addr, ram_wa;
  logic ram_we, ram_wd, ram_q;
  logic rd_valid, rd_ctrl;
  logic [8:0] status_q;
  logic [7:0] busy8;
  logic unused_wd;

  assign opcode      = writedata[31:OPC_LSB];
  assign is_draw     = (opcode == OP_DRAW);
  assign is_clear    = (opcode == OP_CLEAR);
  assign waitrequest = write & ((is_draw & (&busy)) | clearing);
  assign accept      = write & ~waitrequest;
  assign abort_all   = accept & is_clear;
  assign busy8       = 8'(busy);
  assign unused_wd   = ^writedata;

  // Dispatch a DRAW to the lowest-index idle engine
  always_comb begin
    start = '0;
    found = 1'b0;
    for (int i = 0; i < int'(ENGINES); i++) begin
      if (!busy[i] && !found) begin
        start[i] = accept & is_draw;
        found    = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < ENGINES; g++) begin : g_eng
    circle_engine #(.XW(XW), .YW(YW), .RW(RW)) u_engine (
      .clk   (clk),
      .reset (reset),
      .start (start[g]),
      .abort (abort_all),
      .cx    (writedata[XW-1:0]),
      .cy    (writedata[CY_LSB +: YW]),
      .r     (writedata[R_LSB +: RW]),
      .req   (req[g]),
      .gnt   (gnt[g]),
      .px    (px[g]),
      .py    (py[g]),
      .busy  (busy[g])
    );
  end

  // Round-robin search starting at ptr; the sweep owns the port while clearing
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int n = 0; n < int'(ENGINES); n++) begin
      idx = EW'((int'(ptr) + n) % int'(ENGINES));
      if (req[idx] && !gnt_any && !clearing) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        gnt_any  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr      <= '0;
      clearing <= 1'b0;
      clr_addr <= '0;
    end else begin
      if (gnt_any) ptr <= (gnt_idx == EW'(ENGINES - 1)) ? '0 : gnt_idx + EW'(1);
      if (abort_all) begin
        clearing <= 1'b1;
        clr_addr <= '0;
      end else if (clearing) begin
        clr_addr <= clr_addr + AW'(1);
        if (&clr_addr) clearing <= 1'b0;
      end
    end
  end

  assign ram_we = clearing | gnt_any;
  assign ram_wa = clearing ? clr_addr : {py[gnt_idx], px[gnt_idx]};
  assign ram_wd = ~clearing;

  circle_raster_array_ram #(.AW(AW), .DATA_WIDTH(1)) u_ram (
    .clk     (clk),
    .we_a    (ram_we),
    .addr_a  (ram_wa),
    .wdata_a (ram_wd),
    .addr_b  (address[AW-1:0]),
    .rdata_b (ram_q)
  );

  // Read pipeline: status is snapshotted in the read cycle to line up with the RAM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_ctrl  <= 1'b0;
      status_q <= '0;
    end else begin
      rd_valid <= read;
      rd_ctrl  <= address[AW];
      if (read) status_q <= {clearing, busy8};
    end
  end

  assign readdatavalid = rd_valid;

  always_comb begin
    readdata = '0;
    if (rd_valid) readdata = rd_ctrl ? {23'b0, status_q} : {31'b0, ram_q};
  end

endmodule

// File: tb/tb_circle_raster_array.sv
// Self-checking bench for circle_raster_array on a 64x64 bitmap with three engines,
// checked against a plain-arithmetic midpoint-circle bitmap model.
module tb_circle_raster_array;

  localparam int XW   = 6;
  localparam int YW   = 6;
  localparam int RW   = 6;
  localparam int ENG  = 3;
  localparam int AW   = XW + YW;
  localparam int AW1  = AW + 1;
  localparam int NPIX = 1 << AW;
  localparam int DIM  = 1 << XW;
  localparam logic [AW:0] STAT_ADDR = AW1'(1 << AW);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [AW:0] address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;

  int passed = 0;
  int total  = 0;
  bit model [NPIX];

  circle_raster_array #(.XW(XW), .YW(YW), .RW(RW), .ENGINES(ENG)) dut (
    .clk           (clk),
    .reset         (reset),
    .address       (address),
    .read          (read),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .write         (write),
    .writedata     (writedata),
    .waitrequest   (waitrequest)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] draw_cmd(input int cx, input int cy, input int r);
    logic [31:0] c;
    c = '0;
    c[31:28]         = 4'd1;
    c[XW-1:0]        = cx[XW-1:0];
    c[AW-1:XW]       = cy[YW-1:0];
    c[AW+RW-1:AW]    = r[RW-1:0];
    return c;
  endfunction

  function automatic void model_set(input int x, input int y);
    if (x >= 0 && x < DIM && y >= 0 && y < DIM) model[y * DIM + x] = 1'b1;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NPIX; i++) model[i] = 1'b0;
  endfunction

  // Textbook midpoint circle with eightfold symmetry
  function automatic void model_draw(input int cx, input int cy, input int r);
    int x = r;
    int y = 0;
    int d = 1 - r;
    while (x >= y) begin
      model_set(cx + x, cy + y); model_set(cx + x, cy - y);
      model_set(cx - x, cy + y); model_set(cx - x, cy - y);
      model_set(cx + y, cy + x); model_set(cx + y, cy - x);
      model_set(cx - y, cy + x); model_set(cx - y, cy - x);
      y++;
      if (d < 0) d += 2 * y + 1;
      else begin
        x--;
        d += 2 * (y - x) + 1;
      end
    end
  endfunction

  task automatic do_write(input logic [31:0] cmd, output int stall);
    @(negedge clk);
    write = 1'b1;
    writedata = cmd;
    #1;
    stall = 0;
    while (waitrequest && stall < 6000) begin
      @(negedge clk); #1;
      stall++;
    end
    check("write_accept", 32'(waitrequest), 32'd0);
    if (!waitrequest) @(posedge clk);
    #1 write = 1'b0;
  endtask

  task automatic do_read(input logic [AW:0] a, output logic [31:0] data);
    @(negedge clk);
    read = 1'b1;
    address = a;
    @(posedge clk); #1;
    read = 1'b0;
    check("read_valid", 32'(readdatavalid), 32'd1);
    data = readdata;
  endtask

  task automatic check_pixel(input string tag, input int x, input int y, input logic exp);
    logic [31:0] d;
    do_read(AW1'(y * DIM + x), d);
    check(tag, d, {31'b0, exp});
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] s;
    int n = 0;
    do begin
      do_read(STAT_ADDR, s);
      n++;
    end while (s[8:0] != 9'd0 && n < 6000);
    check(tag, s, 32'd0);
  endtask

  // Back-to-back pixel reads over the whole bitmap, one per cycle
  task automatic scan(input string tag);
    int mism = 0;
    @(negedge clk);
    read = 1'b1;
    address = '0;
    for (int a = 0; a < NPIX; a++) begin
      @(posedge clk); #1;
      if (!readdatavalid || readdata !== {31'b0, model[a]}) mism++;
      if (a == NPIX - 1) read = 1'b0;
      else address = AW1'(a + 1);
    end
    check(tag, 32'(mism), 32'd0);
  endtask

  initial begin
    int st;
    logic [31:0] s;
    int set_x[6] = '{33, 33, 32, 31, 27, 30};
    int set_y[6] = '{30, 31, 32, 33, 29, 27};
    int clr_x[3] = '{31, 30, 34};
    int clr_y[3] = '{31, 30, 30};
    int cx, cy, r;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_readdata", readdata, 32'd0);
    check("rst_rdvalid", 32'(readdatavalid), 32'd0);
    check("rst_waitreq", 32'(waitrequest), 32'd0);
    @(negedge clk) reset = 1'b0;

    do_read(STAT_ADDR, s);
    check("status_after_reset", s, 32'd0);
    @(posedge clk); #1;
    check("rdvalid_single_pulse", 32'(readdatavalid), 32'd0);

    // Clear sweep
    do_write(32'h0000_0000, st);
    check("clear_no_stall", 32'(st), 32'd0);
    do_read(STAT_ADDR, s);
    check("clearing_flag", s, 32'h100);
    wait_idle("idle_after_clear");
    model_clear();

    // Undefined opcode is accepted without effect
    do_write(32'hF000_0123, st);
    check("badop_no_stall", 32'(st), 32'd0);
    do_read(STAT_ADDR, s);
    check("badop_status", s, 32'd0);

    // Small circle, exact pixels
    do_write(draw_cmd(30, 30, 3), st);
    model_draw(30, 30, 3);
    wait_idle("idle_after_r3");
    for (int i = 0; i < 6; i++) check_pixel("r3_set", set_x[i], set_y[i], 1'b1);
    for (int i = 0; i < 3; i++) check_pixel("r3_clear", clr_x[i], clr_y[i], 1'b0);

    // Edge clipping, no wrap-around
    do_write(draw_cmd(1, 1, 3), st);
    model_draw(1, 1, 3);
    wait_idle("idle_after_edge");
    check_pixel("edge_x4", 4, 1, 1'b1);
    check_pixel("edge_y4", 1, 4, 1'b1);
    check_pixel("nowrap_x", DIM - 2, 1, 1'b0);
    check_pixel("nowrap_y", 1, DIM - 2, 1'b0);

    // Saturate the engines, fourth DRAW must stall
    do_write(draw_cmd(20, 20, 20), st);
    check("dispatch0_stall", 32'(st), 32'd0);
    do_write(draw_cmd(43, 20, 20), st);
    check("dispatch1_stall", 32'(st), 32'd0);
    do_write(draw_cmd(20, 43, 20), st);
    check("dispatch2_stall", 32'(st), 32'd0);
    do_read(STAT_ADDR, s);
    check("all_busy", s, 32'h7);
    do_write(draw_cmd(43, 43, 20), st);
    check("fourth_stalled", 32'(st > 0), 32'd1);
    model_draw(20, 20, 20);
    model_draw(43, 20, 20);
    model_draw(20, 43, 20);
    model_draw(43, 43, 20);
    wait_idle("idle_after_four");
    scan("scan_four");

    // Random circles anywhere, including partly off-bitmap
    for (int round = 0; round < 3; round++) begin
      for (int j = 0; j < 5; j++) begin
        cx = int'($urandom_range(DIM - 1, 0));
        cy = int'($urandom_range(DIM - 1, 0));
        r  = int'($urandom_range((1 << RW) - 1, 0));
        do_write(draw_cmd(cx, cy, r), st);
        model_draw(cx, cy, r);
      end
      wait_idle("idle_after_random");
      scan("scan_random");
    end

    // CLEAR aborts busy engines; a DRAW during the sweep stalls until it ends
    do_write(draw_cmd(32, 32, 30), st);
    do_write(draw_cmd(10, 10, 25), st);
    do_write(32'h0000_0000, st);
    check("clear_busy_no_stall", 32'(st), 32'd0);
    do_read(STAT_ADDR, s);
    check("abort_status", s, 32'h100);
    do_write(draw_cmd(5, 60, 0), st);
    check("sweep_stall_len", 32'(st >= NPIX - 16 && st <= NPIX), 32'd1);
    model_clear();
    model_draw(5, 60, 0);
    wait_idle("idle_after_sweep");
    scan("scan_after_sweep");

    // Reset mid-draw, then a single-pixel circle
    do_write(draw_cmd(32, 32, 40), st);
    repeat (20) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    do_read(STAT_ADDR, s);
    check("status_after_midreset", s, 32'd0);
    do_write(draw_cmd(5, 7, 0), st);
    wait_idle("idle_after_r0");
    check_pixel("r0_pixel", 5, 7, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/circle_raster_array.md
Name: circle_raster_array

Overview:
- Avalon-MM slave that rasterises circles into a 1-bit-per-pixel bitmap using ENGINES parallel midpoint-circle engines.
- Engines share one arbitrated write port into a dual-port bitmap RAM. The second port serves pixel readback.
- Successor to the fixed three-engine plotter. Adds:
  - parametrised coordinate, radius and engine widths
  - automatic dispatch to a free engine, with backpressure
  - edge clipping instead of wrap-around
  - hardware clear sweep
  - status readback

Parameters:
XW, 9, x coordinate width (bitmap width 2**XW)
YW, 9, y coordinate width (bitmap height 2**YW)
RW, 8, radius width; XW+YW+RW <= 28 (elaboration error otherwise)
ENGINES, 3, number of parallel circle engines (1..8)

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
address  in  XW+YW+1  bit[XW+YW]=1 control space; else pixel address {y,x}
read  in  1  Avalon read strobe
readdata  out  32  read result
readdatavalid  out  1  read result valid
write  in  1  Avalon write strobe
writedata  in  32  command word
waitrequest  out  1  stall; master holds write/writedata while high

Behaviour:
- Reset values:
  - readdata=0, readdatavalid=0, waitrequest=0
  - all engines IDLE, clear sweep inactive
  - bitmap RAM contents not reset
- Command word:
  - [31:28] opcode; 0=CLEAR, 1=DRAW, others ignored (accepted, no effect).
  - DRAW payload: cx=[XW-1:0], cy=[XW+YW-1:XW], r=[XW+YW+RW-1:XW+YW].
- Write acceptance:
  - A write is accepted on the cycle write=1 and waitrequest=0.
  - waitrequest = write & ((opcode==DRAW & no engine IDLE) | clear sweep active).
  - waitrequest is combinational from write/writedata and state; it is never asserted for reads.
- DRAW dispatch:
  - Goes to the lowest-index IDLE engine.
  - That engine leaves IDLE on the next clock.
- CLEAR:
  - Aborts all engines to IDLE.
  - Then writes 0 to every address, one per cycle, 0 to 2**(XW+YW)-1.
  - The sweep owns the write port exclusively; status clearing=1 for its duration.
- Engine FSM:
  - IDLE: on dispatch, load x=r, y=0, d=1-r (signed, RW+2 bits), octant k=0 → PLOT.
  - PLOT: request a write of octant point k:
    - k=0..3 → (cx±x, cy±y)
    - k=4..7 → (cx±y, cy±x)
    - sign order: ++, +-, -+, --
    - On grant, or when the point is clipped, k++. After k=7 → STEP.
    - While not granted, hold k.
  - STEP:
    - y'=y+1.
    - If d<0: d+=2y'+1.
    - Else: x--, d+=2(y'-x')+1.
    - If x'>=y' → PLOT with k=0; else → IDLE.
- Clipping:
  - Coordinates are computed at XW+1 / YW+1 bits signed.
  - A point with any coordinate <0 or >max is skipped in one cycle with no write.
  - No wrap-around.
- Write arbiter:
  - Round-robin among requesting engines; one grant per cycle.
  - The pointer advances past the granted engine.
  - Writes data 1 to RAM port A.
- Pixel read (address[XW+YW]=0):
  - RAM port B read.
  - One cycle later: readdatavalid=1, readdata={31'b0, pixel}.
- Control read (address[XW+YW]=1):
  - One cycle later: readdatavalid=1.
  - readdata = {23'b0, clearing, zero-extended engine busy mask [7:0]}.
- readdatavalid is high exactly one cycle per accepted read; back-to-back reads are supported.
- Simultaneous events:
  - A same-cycle read of a pixel being written returns the old value (read-during-write = old data).
  - Reads are serviced during draws and during a clear sweep.
- Reset mid-draw or mid-clear:
  - All FSMs go to IDLE immediately.
  - Partially written bitmap is retained.
- r=0 plots the single pixel (cx,cy), written 8 times (duplicates permitted).

Decomposition:
- Package circle_raster_pkg holds:
  - opcode constants OP_CLEAR, OP_DRAW
  - engine state enum IDLE/PLOT/STEP
  - field-offset localparams derived from XW/YW/RW
- Sub-module circle_engine:
  - midpoint FSM plus clipping
  - ports: start, cx, cy, r, req, gnt, px, py, busy, abort
- The top level holds:
  - round-robin arbiter
  - clear sweep counter
  - Avalon decode
  - dual-port RAM instance (true dual-port single-clock template, DATA_WIDTH=1)

Test Plan:
- Reset, then status read → readdata=0 after one cycle, readdatavalid pulses once; waitrequest=0.
- CLEAR, then DRAW cx=100 cy=100 r=3, poll status until 0:
  - Set: (103,100), (103,101), (102,102), (101,103), (97,99), (100,97).
  - Clear: (101,101), (100,100), (104,100).
- DRAW cx=1 cy=1 r=3 → (4,1)=1 and (1,4)=1; (510,1)=0 and (1,510)=0 (no wrap); no X on RAM address.
- Four back-to-back DRAWs r=20, ENGINES=3:
  - First three accepted with status busy=3'b111.
  - Fourth sees waitrequest=1 until an engine finishes, then is accepted.
  - All four circles are present.
- CLEAR issued while two engines are busy:
  - Engines abort; clearing=1 for 2**18 cycles.
  - A DRAW during the sweep stalls.
  - Afterwards all sampled pixels read 0.
- Assert reset mid-draw:
  - Status=0 on the next read.
  - A subsequent DRAW r=0 at (5,7) sets pixel (5,7)=1.
